// File: rtl/except_ctrl_pkg.sv
// except_ctrl_pkg: exception flag, CP0 view and request types shared by the MEM-stage exception logic.
package except_ctrl_pkg;
  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;
  localparam logic [4:0] EXCCODE_TR   = 5'd13;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  typedef struct packed {
    logic if_adel, ri, ov, syscall, brk, trap, adel, ades, eret;
  } ExcFlags_t;
  typedef struct packed {
    logic [31:0] status, cause, epc, count, compare;
  } CP0Regs_t;
  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } RegWriteReq_t;
  typedef struct packed {
    logic        flush;
    logic        delayslot;
    logic [31:0] cur_pc;
    logic [4:0]  exc_code;
    logic        eret;
  } ExceptReq_t;
endpackage

// File: rtl/int_sync.sv
// int_sync: STAGES-deep flop chain bringing one asynchronous line into the clk domain.
module int_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/except_ctrl.sv
// except_ctrl: MEM-stage exception arbiter producing the prioritised flush/redirect request for cp0.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BEV     = 32'hBFC00380,
  parameter logic [31:0] VEC_NORMAL  = 32'h80000180
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_valid,
  input  logic [31:0]  mem_pc,
  input  logic         mem_delayslot,
  input  ExcFlags_t    mem_exc,
  input  logic [31:0]  mem_addr,
  input  logic [5:0]   hw_int,
  input  CP0Regs_t     cp0_regs,
  input  RegWriteReq_t cp0_wr,
  output ExceptReq_t   except_req,
  output logic [31:0]  badvaddr,
  output logic [31:0]  redirect_pc,
  output logic [5:0]   ip_hw
);
  logic [5:0]  sync_hw;
  logic        timer_pend_q, timer_pend_d, blank_q, blank_d;
  logic        int_req, active, hit;
  logic [4:0]  code;
  logic [31:0] bad;
  logic        unused_ok;
  for (genvar i = 0; i < 6; i++) begin : g_sync
    int_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(hw_int[i]), .q(sync_hw[i]));
  end
  assign ip_hw     = sync_hw | {timer_pend_q, 5'b0};
  assign unused_ok = ^{cp0_wr.wdata, cp0_regs.status, cp0_regs.cause};
  // A compare write acknowledges the timer and overrides a match in the same cycle.
  always_comb begin
    timer_pend_d = (cp0_wr.we && cp0_wr.waddr == CP0_REG_COMPARE) ? 1'b0 :
                   (cp0_regs.count == cp0_regs.compare) ? 1'b1 : timer_pend_q;
    blank_d      = except_req.flush;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      timer_pend_q <= 1'b0;
      blank_q      <= 1'b0;
    end else begin
      timer_pend_q <= timer_pend_d;
      blank_q      <= blank_d;
    end
  assign int_req = cp0_regs.status[0] & ~cp0_regs.status[1] &
                   |({ip_hw, cp0_regs.cause[9:8]} & cp0_regs.status[15:8]);
  assign active  = rst_n & mem_valid & ~blank_q;
  always_comb begin
    hit  = 1'b1;
    code = '0;
    bad  = '0;
    if (int_req)                code = EXCCODE_INT;
    else if (mem_exc.if_adel) begin
      code = EXCCODE_ADEL;
      bad  = mem_pc;
    end
    else if (mem_exc.ri)        code = EXCCODE_RI;
    else if (mem_exc.ov)        code = EXCCODE_OV;
    else if (mem_exc.syscall)   code = EXCCODE_SYS;
    else if (mem_exc.brk)       code = EXCCODE_BP;
    else if (mem_exc.trap)      code = EXCCODE_TR;
    else if (mem_exc.adel) begin
      code = EXCCODE_ADEL;
      bad  = mem_addr;
    end
    else if (mem_exc.ades) begin
      code = EXCCODE_ADES;
      bad  = mem_addr;
    end
    else                        hit  = 1'b0;
  end
  always_comb begin
    except_req  = '0;
    badvaddr    = '0;
    redirect_pc = '0;
    if (active && hit) begin
      except_req.flush     = 1'b1;
      except_req.delayslot = mem_delayslot;
      except_req.cur_pc    = mem_pc;
      except_req.exc_code  = code;
      badvaddr             = bad;
      redirect_pc          = cp0_regs.status[22] ? VEC_BEV : VEC_NORMAL;
    end else if (active && mem_exc.eret) begin
      except_req.flush = 1'b1;
      except_req.eret  = 1'b1;
      redirect_pc      = cp0_regs.epc;
    end
  end
endmodule
